// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the IF/LSU memory request arbiter.
//   arb_state_e : transaction FSM states (idle, issue, wait)
//   owner_e     : which requester owns the outstanding transaction
//   Len*        : legal byte counts for memory commands
//   norm_len    : maps an illegal byte count onto a full word
//   len_mask    : byte-lane mask for a (normalised) byte count
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

  localparam logic [2:0] LenByte = 3'd1;
  localparam logic [2:0] LenHalf = 3'd2;
  localparam logic [2:0] LenWord = 3'd4;

  function automatic logic [2:0] norm_len(input logic [2:0] len);
    logic [2:0] res;
    case (len)
      LenByte: res = LenByte;
      LenHalf: res = LenHalf;
      default: res = LenWord;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] len_mask(input logic [2:0] len);
    logic [31:0] res;
    case (len)
      LenByte: res = 32'h0000_00ff;
      LenHalf: res = 32'h0000_ffff;
      default: res = 32'hffff_ffff;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_starve_counter.sv
// Saturating counter of LSU grants taken while a fetch is waiting.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_inc        : count one LSU grant (saturates at LIMIT)
//   i_clr        : clear to zero (wins over i_inc)
//   o_at_limit   : count has reached LIMIT
module mem_req_arbiter_starve_counter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LimitVal)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LimitVal);

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter between instruction fetch and the load/store unit for a
// byte-serial memory controller. LSU has priority; a starvation guard forces a fetch through
// after STARVE_LIMIT LSU grants. A pipeline flush kills an in-flight fetch response.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_flush                         : redirect, kills the fetch transaction
//   i_if_req/i_if_addr              : fetch request; o_if_valid/o_if_inst return the word
//   i_lsu_req/we/addr/len/wdata     : load/store request; o_lsu_done/o_lsu_rdata respond
//   o_cmd_valid/i_cmd_ready/o_cmd_* : command channel to the memory controller
//   i_rsp_valid/i_rsp_data          : controller completion and read data
//   o_busy                          : a transaction is outstanding
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STARVE_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_valid,
  output logic [31:0] o_if_inst,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [31:0] i_lsu_addr,
  input  logic [2:0]  i_lsu_len,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_cmd_we,
  output logic [31:0] o_cmd_addr,
  output logic [2:0]  o_cmd_len,
  output logic [31:0] o_cmd_wdata,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  output logic        o_busy
);

  arb_state_e  r_state, w_state_nxt;
  owner_e      r_owner, w_owner_nxt;
  logic        r_kill, w_kill_nxt;
  logic        r_cmd_we, w_cmd_we_nxt;
  logic [31:0] r_cmd_addr, w_cmd_addr_nxt;
  logic [2:0]  r_cmd_len, w_cmd_len_nxt;
  logic [31:0] r_cmd_wdata, w_cmd_wdata_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_inst, w_if_inst_nxt;
  logic        r_lsu_done, w_lsu_done_nxt;
  logic [31:0] r_lsu_rdata, w_lsu_rdata_nxt;

  logic w_at_limit, w_starve_inc, w_starve_clr;
  logic w_force_if, w_lsu_elig, w_if_elig, w_grant_if, w_grant_lsu;
  logic [2:0] w_lsu_len;

  mem_req_arbiter_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .WIDTH (STARVE_W)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_starve_inc),
    .i_clr      (w_starve_clr),
    .o_at_limit (w_at_limit)
  );

  // A requester still holds its request in the cycle its done pulse is out, so that
  // cycle must not re-grant it.
  assign w_force_if  = (STARVE_LIMIT != 0) && w_at_limit && i_if_req;
  assign w_lsu_elig  = i_lsu_req && !r_lsu_done;
  assign w_if_elig   = i_if_req && !r_if_valid && !i_flush;
  assign w_grant_if  = w_force_if || (!w_lsu_elig && w_if_elig);
  assign w_grant_lsu = !w_force_if && w_lsu_elig;
  assign w_lsu_len   = norm_len(i_lsu_len);

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_kill_nxt      = r_kill;
    w_cmd_we_nxt    = r_cmd_we;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_len_nxt   = r_cmd_len;
    w_cmd_wdata_nxt = r_cmd_wdata;
    w_if_valid_nxt  = 1'b0;
    w_if_inst_nxt   = r_if_inst;
    w_lsu_done_nxt  = 1'b0;
    w_lsu_rdata_nxt = r_lsu_rdata;
    w_starve_inc    = 1'b0;
    w_starve_clr    = 1'b0;
    case (r_state)
      ArbIdle: begin
        if (!i_if_req) w_starve_clr = 1'b1;
        if (w_grant_if) begin
          w_state_nxt     = ArbIssue;
          w_owner_nxt     = OwnIf;
          w_cmd_we_nxt    = 1'b0;
          w_cmd_addr_nxt  = i_if_addr;
          w_cmd_len_nxt   = LenWord;
          w_cmd_wdata_nxt = '0;
          w_starve_clr    = 1'b1;
        end else if (w_grant_lsu) begin
          w_state_nxt     = ArbIssue;
          w_owner_nxt     = OwnLsu;
          w_cmd_we_nxt    = i_lsu_we;
          w_cmd_addr_nxt  = i_lsu_addr;
          w_cmd_len_nxt   = w_lsu_len;
          w_cmd_wdata_nxt = i_lsu_wdata & len_mask(w_lsu_len);
          w_starve_inc    = i_if_req;
        end
      end
      ArbIssue: begin
        if (i_flush && (r_owner == OwnIf)) w_kill_nxt = 1'b1;
        if (i_cmd_ready) w_state_nxt = ArbWait;
      end
      ArbWait: begin
        if (i_flush && (r_owner == OwnIf)) w_kill_nxt = 1'b1;
        if (i_rsp_valid) begin
          w_state_nxt = ArbIdle;
          w_kill_nxt  = 1'b0;
          if (r_owner == OwnLsu) begin
            w_lsu_done_nxt  = 1'b1;
            w_lsu_rdata_nxt = i_rsp_data & len_mask(r_cmd_len);
          end else if (!(r_kill || i_flush)) begin
            // A flush in the response cycle is not yet in r_kill but still kills.
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = i_rsp_data;
          end
        end
      end
      default: w_state_nxt = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ArbIdle;
      r_owner     <= OwnIf;
      r_kill      <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
      r_cmd_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_if_inst   <= '0;
      r_lsu_done  <= 1'b0;
      r_lsu_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_kill      <= w_kill_nxt;
      r_cmd_we    <= w_cmd_we_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_len   <= w_cmd_len_nxt;
      r_cmd_wdata <= w_cmd_wdata_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_lsu_done  <= w_lsu_done_nxt;
      r_lsu_rdata <= w_lsu_rdata_nxt;
    end
  end

  assign o_cmd_valid = (r_state == ArbIssue);
  assign o_busy      = (r_state != ArbIdle);
  assign o_cmd_we    = r_cmd_we;
  assign o_cmd_addr  = r_cmd_addr;
  assign o_cmd_len   = r_cmd_len;
  assign o_cmd_wdata = r_cmd_wdata;
  assign o_if_valid  = r_if_valid;
  assign o_if_inst   = r_if_inst;
  assign o_lsu_done  = r_lsu_done;
  assign o_lsu_rdata = r_lsu_rdata;

endmodule
